fetch_prefetch: RTL and testbench

- Instruction-fetch master that sits directly upstream of the word-wide ROM/memory slaves on the bus.
- Issues sequential word reads using the bstart/bdone handshake.
- Buffers returned words in a small FIFO and hands them to the core decode stage over valid/ready.
- Supports a redirect that flushes the buffer and restarts fetch at a new PC.

---
 rtl/fetch_prefetch.sv | 197 +++++++++++++++++++
 tb/tb_fetch_prefetch.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch.sv
// rtl/fetch_prefetch.sv - sequential instruction prefetch master with word FIFO and redirect; optional FETCH_ALIGN_CHECK_EN
module fetch_prefetch #(
    parameter int            DEPTH    = 2,
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [31:0]   instr,
    output logic [AW-1:0] instr_pc,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic          instr_misalign,
`endif
    output logic          bus_bstart,
    output logic [AW-1:0] bus_addr,
    input  logic [31:0]   bus_rdata,
    input  logic          bus_bdone
);

    localparam int          PW      = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          drop_q, drop_d;
    logic [PW:0]   count_q, count_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [31:0]   mem_instr_q [DEPTH];
    logic [31:0]   mem_instr_d [DEPTH];
    logic [AW-1:0] mem_pc_q [DEPTH];
    logic [AW-1:0] mem_pc_d [DEPTH];

    logic          push;
    logic          pop;
    logic          issue_ok;
    logic [31:0]   push_instr;
    logic [AW-1:0] push_pc;
    logic [AW-1:0] redirect_tgt;

`ifdef FETCH_ALIGN_CHECK_EN
    logic          mem_mis_q [DEPTH];
    logic          mem_mis_d [DEPTH];
    logic          halt_q, halt_d;
    logic          nop_pend_q, nop_pend_d;
    logic          push_mis;
    logic          misaligned;

    assign redirect_tgt   = redirect_pc;
    assign misaligned     = |redirect_pc[1:0];
    assign instr_misalign = instr_valid ? mem_mis_q[rptr_q] : 1'b0;
`else
    assign redirect_tgt   = {redirect_pc[AW-1:2], 2'b00};
`endif

    assign instr_valid = (count_q != '0);
    assign instr       = instr_valid ? mem_instr_q[rptr_q] : 32'd0;
    assign instr_pc    = instr_valid ? mem_pc_q[rptr_q] : '0;
    assign bus_addr    = (state_q == S_IDLE) ? pc_q : addr_q;
    assign pop         = instr_valid && instr_ready;

    // Fetch FSM next state, bus strobe, FIFO push/pop and redirect flush
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        drop_d      = drop_q;
        count_d     = count_q;
        rptr_d      = rptr_q;
        wptr_d      = wptr_q;
        mem_instr_d = mem_instr_q;
        mem_pc_d    = mem_pc_q;
        bus_bstart  = 1'b0;
        push        = 1'b0;
        push_instr  = bus_rdata;
        push_pc     = addr_q;
`ifdef FETCH_ALIGN_CHECK_EN
        mem_mis_d   = mem_mis_q;
        halt_d      = halt_q;
        nop_pend_d  = nop_pend_q;
        push_mis    = 1'b0;
        issue_ok    = !halt_q;
`else
        issue_ok    = 1'b1;
`endif

        case (state_q)
            S_IDLE: begin
                // count is the registered value, so a same-cycle pop never frees a slot
                if (!rst && !redirect && issue_ok && (count_q < DEPTH_C)) begin
                    bus_bstart = 1'b1;
                    addr_d     = pc_q;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus_bdone) begin
                    state_d = S_IDLE;
                    drop_d  = 1'b0;
                    if (!drop_q && !redirect) begin
                        push = 1'b1;
                        pc_d = pc_q + AW'(4);
                    end
                end else if (redirect) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef FETCH_ALIGN_CHECK_EN
        // the NOP marker lands the cycle after the misaligned redirect, into an empty FIFO
        if (nop_pend_q) begin
            push       = 1'b1;
            push_instr = NOP;
            push_pc    = pc_q;
            push_mis   = 1'b1;
            nop_pend_d = 1'b0;
        end
`endif

        if (push) begin
            mem_instr_d[wptr_q] = push_instr;
            mem_pc_d[wptr_q]    = push_pc;
`ifdef FETCH_ALIGN_CHECK_EN
            mem_mis_d[wptr_q]   = push_mis;
`endif
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (redirect) begin
            count_d = '0;
            rptr_d  = '0;
            wptr_d  = '0;
            pc_d    = redirect_tgt;
`ifdef FETCH_ALIGN_CHECK_EN
            halt_d     = misaligned;
            nop_pend_d = misaligned;
`endif
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            drop_q     <= 1'b0;
            count_q    <= '0;
            rptr_q     <= '0;
            wptr_q     <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            halt_q     <= 1'b0;
            nop_pend_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
`ifdef FETCH_ALIGN_CHECK_EN
            halt_q     <= halt_d;
            nop_pend_q <= nop_pend_d;
`endif
        end
    end

    // FIFO storage; contents are masked by instr_valid so no reset is needed
    always_ff @(posedge clk) begin
        mem_instr_q <= mem_instr_d;
        mem_pc_q    <= mem_pc_d;
`ifdef FETCH_ALIGN_CHECK_EN
        mem_mis_q   <= mem_mis_d;
`endif
    end

endmodule

// File: tb/tb_fetch_prefetch.sv
// tb/tb_fetch_prefetch.sv - directed self-checking bench for fetch_prefetch
module tb_fetch_prefetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        instr_ready = 1'b0;
    logic        bus_bdone = 1'b0;
    logic [31:0] bus_rdata = 32'd0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        bus_bstart;
    logic [31:0] bus_addr;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        instr_misalign;
`endif

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          b2b = 0;
    logic        prev_bstart = 1'b0;
    int          bs_cyc[$];
    logic [31:0] bs_addr[$];
    logic [31:0] dl_instr[$];
    logic [31:0] dl_pc[$];
    int          slv_cnt = 0;
    logic [31:0] slv_addr = 32'd0;

    always #5 clk = ~clk;

    fetch_prefetch #(.DEPTH(2), .AW(32), .RESET_PC(32'h0)) dut (
        .clk(clk),
        .rst(rst),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr(instr),
        .instr_pc(instr_pc),
`ifdef FETCH_ALIGN_CHECK_EN
        .instr_misalign(instr_misalign),
`endif
        .bus_bstart(bus_bstart),
        .bus_addr(bus_addr),
        .bus_rdata(bus_rdata),
        .bus_bdone(bus_bdone)
    );

    // slave: bdone two cycles after bstart, data = 0xA0 + word index
    always @(negedge clk) begin
        if (rst) begin
            slv_cnt   = 0;
            bus_bdone = 1'b0;
        end else begin
            bus_bdone = 1'b0;
            if (slv_cnt > 0) begin
                slv_cnt--;
                if (slv_cnt == 0) begin
                    bus_bdone = 1'b1;
                    bus_rdata = 32'hA0 + (slv_addr >> 2);
                end
            end
            if (bus_bstart) begin
                slv_cnt  = 2;
                slv_addr = bus_addr;
            end
        end
    end

    // monitor: cycle count, bstart log, delivered-word log
    always @(negedge clk) begin
        if (rst) begin
            cyc         = 0;
            prev_bstart = 1'b0;
        end else begin
            cyc++;
            if (bus_bstart) begin
                bs_cyc.push_back(cyc);
                bs_addr.push_back(bus_addr);
                if (prev_bstart) b2b++;
            end
            prev_bstart = bus_bstart;
            if (instr_valid && instr_ready) begin
                dl_instr.push_back(instr);
                dl_pc.push_back(instr_pc);
            end
        end
    end

    task automatic do_reset;
        @(posedge clk); #1;
        rst = 1'b1; redirect = 1'b0; instr_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bs_cyc.delete(); bs_addr.delete(); dl_instr.delete(); dl_pc.delete();
        b2b = 0;
        rst = 1'b0;
    endtask

    task automatic wait_cycle(input int n);
        int guard = 0;
        while (cyc + 1 < n && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
        tests++;
        if (cyc + 1 != n) begin
            fails++;
            $display("FAIL wait_cycle: at cycle %0d, expected cycle %0d", cyc + 1, n);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h40; instr_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++;
        if (instr_valid !== 1'b0 || bus_bstart !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: valid=%b bstart=%b, expected 0 0", instr_valid, bus_bstart);
        end
        tests++;
        if (bus_addr !== 32'h0) begin
            fails++;
            $display("FAIL reset_addr: got %h, expected 00000000", bus_addr);
        end
        tests++;
        if (instr !== 32'h0 || instr_pc !== 32'h0) begin
            fails++;
            $display("FAIL reset_data: instr=%h pc=%h, expected 0 0", instr, instr_pc);
        end
    endtask

    task automatic test_stream;
        int exp_c[3] = '{1, 4, 7};
        do_reset();
        instr_ready = 1'b1;
        wait_cycle(12);
        tests++;
        if (bs_cyc.size() < 3 || dl_pc.size() < 3) begin
            fails++;
            $display("FAIL stream_count: bstarts=%0d words=%0d, expected >=3 each", bs_cyc.size(), dl_pc.size());
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (bs_cyc[i] !== exp_c[i] || bs_addr[i] !== 32'(4 * i)) begin
                fails++;
                $display("FAIL stream_bstart[%0d]: cycle %0d addr %h, expected cycle %0d addr %h",
                         i, bs_cyc[i], bs_addr[i], exp_c[i], 32'(4 * i));
            end
            tests++;
            if (dl_instr[i] !== 32'(32'hA0 + i) || dl_pc[i] !== 32'(4 * i)) begin
                fails++;
                $display("FAIL stream_word[%0d]: instr %h pc %h, expected %h %h",
                         i, dl_instr[i], dl_pc[i], 32'(32'hA0 + i), 32'(4 * i));
            end
        end
        tests++;
        if (b2b !== 0) begin
            fails++;
            $display("FAIL stream_b2b: %0d back-to-back bstarts, expected 0", b2b);
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        wait_cycle(20);
        tests++;
        if (bs_cyc.size() !== 2 || bs_addr[0] !== 32'h0 || bs_addr[1] !== 32'h4) begin
            fails++;
            $display("FAIL bp_issue: %0d bstarts (addr %h %h), expected 2 (0 4)", bs_cyc.size(), bs_addr[0], bs_addr[1]);
        end
        tests++;
        if (instr_valid !== 1'b1 || instr !== 32'hA0 || instr_pc !== 32'h0) begin
            fails++;
            $display("FAIL bp_head: valid=%b instr=%h pc=%h, expected 1 a0 0", instr_valid, instr, instr_pc);
        end
        wait_cycle(21);
        instr_ready = 1'b1;
        wait_cycle(25);
        tests++;
        if (bs_cyc[2] !== 22 || bs_addr[2] !== 32'h8) begin
            fails++;
            $display("FAIL bp_resume: bstart cycle %0d addr %h, expected 22 00000008", bs_cyc[2], bs_addr[2]);
        end
        tests++;
        if (dl_instr[0] !== 32'hA0 || dl_pc[1] !== 32'h4) begin
            fails++;
            $display("FAIL bp_order: first %h second pc %h, expected a0 4", dl_instr[0], dl_pc[1]);
        end
    endtask

    task automatic test_redirect_wait;
        do_reset();
        instr_ready = 1'b1;
        wait_cycle(8);
        redirect = 1'b1; redirect_pc = 32'h100;
        wait_cycle(9);
        redirect = 1'b0;
        tests++;
        if (instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL rw_flush: valid=%b, expected 0", instr_valid);
        end
        wait_cycle(16);
        tests++;
        if (bs_addr[2] !== 32'h8 || bs_cyc[3] !== 10 || bs_addr[3] !== 32'h100) begin
            fails++;
            $display("FAIL rw_restart: addr2 %h, bstart3 cycle %0d addr %h, expected 8, 10, 100",
                     bs_addr[2], bs_cyc[3], bs_addr[3]);
        end
        tests++;
        if (dl_pc[2] !== 32'h100 || dl_instr[2] !== 32'hE0) begin
            fails++;
            $display("FAIL rw_word: pc %h instr %h, expected 100 e0", dl_pc[2], dl_instr[2]);
        end
    endtask

    task automatic test_redirect_bdone;
        do_reset();
        wait_cycle(6);
        redirect = 1'b1; redirect_pc = 32'h200;
        wait_cycle(7);
        redirect = 1'b0;
        tests++;
        if (instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL rb_flush: valid=%b, expected 0", instr_valid);
        end
        instr_ready = 1'b1;
        wait_cycle(12);
        tests++;
        if (bs_cyc[2] !== 7 || bs_addr[2] !== 32'h200) begin
            fails++;
            $display("FAIL rb_restart: cycle %0d addr %h, expected 7 200", bs_cyc[2], bs_addr[2]);
        end
        tests++;
        if (dl_pc[0] !== 32'h200 || dl_instr[0] !== 32'h120) begin
            fails++;
            $display("FAIL rb_word: pc %h instr %h, expected 200 120", dl_pc[0], dl_instr[0]);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] exp_pc[3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        do_reset();
        instr_ready = 1'b1;
        wait_cycle(2);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        wait_cycle(3);
        redirect = 1'b0;
        wait_cycle(14);
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (dl_pc[i] !== exp_pc[i]) begin
                fails++;
                $display("FAIL wrap_pc[%0d]: got %h, expected %h", i, dl_pc[i], exp_pc[i]);
            end
        end
        tests++;
        if (dl_instr[2] !== 32'hA0) begin
            fails++;
            $display("FAIL wrap_data: got %h, expected a0", dl_instr[2]);
        end
    endtask

    task automatic test_align;
        do_reset();
        wait_cycle(2);
        redirect = 1'b1; redirect_pc = 32'h102;
        wait_cycle(3);
        redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        wait_cycle(10);
        tests++;
        if (instr_valid !== 1'b1 || instr !== 32'h13 || instr_pc !== 32'h102 || instr_misalign !== 1'b1) begin
            fails++;
            $display("FAIL align_nop: valid=%b instr=%h pc=%h mis=%b, expected 1 13 102 1",
                     instr_valid, instr, instr_pc, instr_misalign);
        end
        tests++;
        if (bs_cyc.size() !== 1) begin
            fails++;
            $display("FAIL align_halt: %0d bstarts, expected 1", bs_cyc.size());
        end
`else
        wait_cycle(8);
        tests++;
        if (bs_addr[1] !== 32'h100) begin
            fails++;
            $display("FAIL align_addr: got %h, expected 100", bs_addr[1]);
        end
        tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== 32'hE0) begin
            fails++;
            $display("FAIL align_head: valid=%b pc=%h instr=%h, expected 1 100 e0", instr_valid, instr_pc, instr);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_bdone();
        test_wrap();
        test_align();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
